// File: rtl/iob_cache_mem_arbiter_if.sv
// iob_cache_mem_arbiter_if: native memory bus bundle with N request lanes sharing one read-data return
interface iob_cache_mem_arbiter_if #(
    parameter int N  = 1,
    parameter int AW = 12,
    parameter int DW = 32
) ();
    logic [N-1:0]        valid;
    logic [N*AW-1:0]     addr;
    logic [N*DW-1:0]     wdata;
    logic [N*DW/8-1:0]   wstrb;
    logic [DW-1:0]       rdata;
    logic [N-1:0]        ready;
    modport master (output valid, addr, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_cache_mem_arbiter.sv
// iob_cache_mem_arbiter: round-robin merge of N cache back-ends onto one memory port; ARB_BURST_LOCK_EN keeps read bursts contiguous
module iob_cache_mem_arbiter #(
    parameter int N_MASTERS    = 2,
    parameter int BE_ADDR_W    = 12,
    parameter int BE_DATA_W    = 32,
    parameter int BURST_LEN    = 2,
    parameter int LOCK_TIMEOUT = 8
) (
    input logic                     clk,
    input logic                     reset,
    iob_cache_mem_arbiter_if.slave  m,
    iob_cache_mem_arbiter_if.master mem
);
    localparam int GNT_W     = $clog2(N_MASTERS);
    localparam int BE_NBYTES = BE_DATA_W / 8;
    typedef enum logic [1:0] {IDLE, BUSY, LOCK} state_t;
    state_t state, state_nxt;
    logic [GNT_W-1:0] grant, grant_nxt, rr_ptr, rr_nxt, sel;
    logic lock;
    if (BURST_LEN < 1 || LOCK_TIMEOUT < 1) begin : g_bad_cfg
        $error("BURST_LEN and LOCK_TIMEOUT must be >= 1");
    end
`ifdef ARB_BURST_LOCK_EN
    localparam int BW = $clog2(BURST_LEN + 1) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    logic [BW-1:0] burst_cnt, burst_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    assign lock = (mem.wstrb == '0) && (burst_cnt + BW'(1) < BW'(BURST_LEN));
`else
    assign lock = 1'b0;
`endif
    assign mem.addr  = m.addr[grant*BE_ADDR_W +: BE_ADDR_W];
    assign mem.wdata = m.wdata[grant*BE_DATA_W +: BE_DATA_W];
    assign mem.wstrb = m.wstrb[grant*BE_NBYTES +: BE_NBYTES];
    assign m.rdata   = mem.rdata;
    // first requesting master at or after rr_ptr, wrapping around
    always_comb begin
        sel = rr_ptr;
        for (int k = N_MASTERS - 1; k >= 0; k--)
            if (m.valid[rr_ptr + GNT_W'(k)]) sel = rr_ptr + GNT_W'(k);
    end
    // next state, grant/pointer bookkeeping and handshake outputs
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        mem.valid = 1'b0;
        m.ready   = '0;
`ifdef ARB_BURST_LOCK_EN
        burst_nxt = burst_cnt;
        tmo_nxt   = tmo_cnt;
`endif
        case (state)
            IDLE: if (|m.valid) begin
                grant_nxt = sel;
                state_nxt = BUSY;
`ifdef ARB_BURST_LOCK_EN
                burst_nxt = '0;
`endif
            end
            BUSY: begin
                mem.valid = m.valid[grant];
                if (mem.ready[0]) begin
                    m.ready[grant] = 1'b1;
                    rr_nxt         = grant + 1'b1;
                    state_nxt      = lock ? LOCK : IDLE;
`ifdef ARB_BURST_LOCK_EN
                    tmo_nxt = '0;
                    if (mem.wstrb == '0) burst_nxt = burst_cnt + 1'b1;
`endif
                end
            end
`ifdef ARB_BURST_LOCK_EN
            LOCK: if (m.valid[grant]) begin
                state_nxt = BUSY;
                tmo_nxt   = '0;
            end else begin
                tmo_nxt = tmo_cnt + 1'b1;
                if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end
    // state, grant and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_nxt;
        end
    end
`ifdef ARB_BURST_LOCK_EN
    // burst length and lock idle-timeout counters
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            burst_cnt <= burst_nxt;
            tmo_cnt   <= tmo_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_iob_cache_mem_arbiter.sv
// tb_iob_cache_mem_arbiter: randomized self-checking bench against a transaction-level round-robin model
module tb_iob_cache_mem_arbiter;
    localparam int N = 2, AW = 12, DW = 32, NB = 4, LOCK_TIMEOUT = 8;
`ifdef ARB_BURST_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0, fails = 0, exp_rr = 0;
    logic [N-1:0]  valid_m;
    logic [AW-1:0] addr_m  [N];
    logic [DW-1:0] wdata_m [N];
    logic [NB-1:0] wstrb_m [N];

    iob_cache_mem_arbiter_if #(.N(N), .AW(AW), .DW(DW)) m_if ();
    iob_cache_mem_arbiter_if #(.N(1), .AW(AW), .DW(DW)) mem_if ();

    iob_cache_mem_arbiter #(
        .N_MASTERS(N), .BE_ADDR_W(AW), .BE_DATA_W(DW), .BURST_LEN(2), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .m(m_if), .mem(mem_if)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[(exp_rr + k) % N]) return (exp_rr + k) % N;
        return -1;
    endfunction

    function automatic logic [NB-1:0] rnd_strb(input bit allow_read);
        return (allow_read && !LOCK_EN && $urandom_range(0, 1) == 0) ? '0 : NB'($urandom_range(1, 15));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        mem_if.ready = 1'b0;
        mem_if.rdata = $urandom;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [NB-1:0] ws);
        valid_m[i] = v;
        addr_m[i]  = a;
        wdata_m[i] = wd;
        wstrb_m[i] = ws;
        m_if.valid[i] = v;
        m_if.addr[i*AW +: AW] = a;
        m_if.wdata[i*DW +: DW] = wd;
        m_if.wstrb[i*NB +: NB] = ws;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        exp_rr = 0;
    endtask

    // acts as memory: waits for mem_valid, answers lat cycles later, reports what it saw
    task automatic serve(input int lat, input logic [DW-1:0] rd, output logic [AW-1:0] a, output logic [DW-1:0] wd,
                         output logic [NB-1:0] ws, output logic [N-1:0] rdy, output logic [DW-1:0] rdat,
                         output bit early, output bit to);
        to = 1'b1;
        early = 1'b0;
        a = 'x; wd = 'x; ws = 'x; rdy = 'x; rdat = 'x;
        for (int n = 0; n < 40; n++) begin
            tick();
            #1;
            if (m_if.ready !== '0) early = 1'b1;
            if (mem_if.valid === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        if (to) return;
        a = mem_if.addr;
        wd = mem_if.wdata;
        ws = mem_if.wstrb;
        repeat (lat - 1) begin
            tick();
            #1;
            if (m_if.ready !== '0) early = 1'b1;
        end
        tick();
        mem_if.ready = 1'b1;
        mem_if.rdata = rd;
        #1;
        rdy = m_if.ready;
        rdat = m_if.rdata;
    endtask

    task automatic test_reset();
        logic [AW-1:0] a0;
        a0 = AW'($urandom);
        tick();
        reset = 1'b1;
        set_req(0, 1'b1, a0, DW'($urandom), '0);
        set_req(1, 1'b1, a0 ^ 12'hFFF, DW'($urandom), '0);
        repeat (3) begin
            tick();
            #1;
            tests++;
            if (mem_if.valid !== 1'b0 || m_if.ready !== '0) begin
                fails++;
                $display("FAIL reset_hold: mem_valid=%b m_ready=%b, required 0 and 00", mem_if.valid, m_if.ready);
            end
        end
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if (mem_if.valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_arb_cycle: mem_valid=%b, required 0", mem_if.valid);
        end
        tick();
        #1;
        tests++;
        if (mem_if.valid !== 1'b1 || mem_if.addr !== a0) begin
            fails++;
            $display("FAIL reset_first_grant: mem_valid=%b addr=%h, required 1 and %h", mem_if.valid, mem_if.addr, a0);
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] a; logic [DW-1:0] wd, rd, rdat; logic [NB-1:0] ws; logic [N-1:0] rdy; bit early, to;
        int e;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'($urandom), DW'($urandom), rnd_strb(1'b0));
        for (int t = 0; t < 8; t++) begin
            e = pick(valid_m);
            rd = $urandom;
            serve(2, rd, a, wd, ws, rdy, rdat, early, to);
            tests++;
            if (to || early || a !== addr_m[e] || rdy !== N'(1 << e) || rdat !== rd) begin
                fails++;
                $display("FAIL contention[%0d]: to=%0b early=%0b addr=%h m_ready=%b rdata=%h, required addr=%h m_ready=%b rdata=%h",
                         t, to, early, a, rdy, rdat, addr_m[e], N'(1 << e), rd);
            end
            exp_rr = (e + 1) % N;
            tick();
            set_req(e, 1'b1, AW'($urandom), DW'($urandom), rnd_strb(1'b0));
        end
    endtask

    task automatic test_write();
        logic [AW-1:0] a; logic [DW-1:0] wd, rdat; logic [NB-1:0] ws; logic [N-1:0] rdy; bit early, to, bad;
        do_reset();
        set_req(1, 1'b1, 12'h0A4, 32'hDEADBEEF, 4'hF);
        serve($urandom_range(1, 3), DW'($urandom), a, wd, ws, rdy, rdat, early, to);
        tests++;
        if (to || a !== 12'h0A4 || wd !== 32'hDEADBEEF || ws !== 4'hF) begin
            fails++;
            $display("FAIL write_fields: to=%0b addr=%h wdata=%h wstrb=%h, required 0a4 deadbeef f", to, a, wd, ws);
        end
        tests++;
        if (early || rdy !== 2'b10) begin
            fails++;
            $display("FAIL write_ready: early=%0b m_ready=%b, required 0 and 10", early, rdy);
        end
        tick();
        set_req(1, 1'b0, '0, '0, '0);
        bad = 1'b0;
        repeat (3) begin
            #1;
            if (m_if.ready !== '0) bad = 1'b1;
            tick();
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL write_single_pulse: extra m_ready seen, required none");
        end
    endtask

    task automatic test_read_data();
        logic [AW-1:0] a, ra; logic [DW-1:0] wd, rdat; logic [NB-1:0] ws; logic [N-1:0] rdy; bit early, to;
        do_reset();
        ra = AW'($urandom);
        set_req(0, 1'b1, ra, DW'($urandom), '0);
        serve($urandom_range(1, 3), 32'h12345678, a, wd, ws, rdy, rdat, early, to);
        tests++;
        if (to || early || a !== ra || ws !== '0 || rdy !== 2'b01 || rdat !== 32'h12345678) begin
            fails++;
            $display("FAIL read_data: to=%0b addr=%h wstrb=%h m_ready=%b rdata=%h, required addr=%h wstrb=0 m_ready=01 rdata=12345678",
                     to, a, ws, rdy, rdat, ra);
        end
        tick();
        set_req(0, 1'b0, '0, '0, '0);
        repeat (LOCK_TIMEOUT + 2) tick();
        mem_if.ready = 1'b1;
        #1;
        tests++;
        if (m_if.ready !== '0 || mem_if.valid !== 1'b0) begin
            fails++;
            $display("FAIL spurious_ready: m_ready=%b mem_valid=%b, required 00 and 0", m_if.ready, mem_if.valid);
        end
        tick();
    endtask

    task automatic test_random();
        logic [AW-1:0] a; logic [DW-1:0] wd, rd, rdat; logic [NB-1:0] ws; logic [N-1:0] rdy; bit early, to;
        int e, last;
        do_reset();
        last = -1;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (last >= 0) set_req(last, 1'b0, '0, '0, '0);
            for (int i = 0; i < N; i++)
                if (!valid_m[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'b1, AW'($urandom), DW'($urandom), rnd_strb(1'b1));
            if (valid_m == '0) begin
                last = -1;
                #1;
                tests++;
                if (mem_if.valid !== 1'b0 || m_if.ready !== '0) begin
                    fails++;
                    $display("FAIL random_idle[%0d]: mem_valid=%b m_ready=%b, required 0 and 00", t, mem_if.valid, m_if.ready);
                end
                continue;
            end
            e = pick(valid_m);
            rd = $urandom;
            serve($urandom_range(1, 4), rd, a, wd, ws, rdy, rdat, early, to);
            tests++;
            if (to || early || a !== addr_m[e] || wd !== wdata_m[e] || ws !== wstrb_m[e] || rdy !== N'(1 << e) || rdat !== rd) begin
                fails++;
                $display("FAIL random[%0d]: to=%0b early=%0b addr=%h wdata=%h wstrb=%h m_ready=%b rdata=%h, required %h %h %h %b %h",
                         t, to, early, a, wd, ws, rdy, rdat, addr_m[e], wdata_m[e], wstrb_m[e], N'(1 << e), rd);
            end
            exp_rr = (e + 1) % N;
            last = e;
        end
    endtask

`ifdef ARB_BURST_LOCK_EN
    task automatic test_burst_lock();
        logic [AW-1:0] a; logic [DW-1:0] wd, rdat; logic [NB-1:0] ws; logic [N-1:0] rdy; bit early, to, bad;
        do_reset();
        set_req(0, 1'b1, 12'h100, '0, '0);
        set_req(1, 1'b1, 12'h3C8, DW'($urandom), '0);
        serve(2, DW'($urandom), a, wd, ws, rdy, rdat, early, to);
        tests++;
        if (to || a !== 12'h100 || rdy !== 2'b01) begin
            fails++;
            $display("FAIL burst_first: to=%0b addr=%h m_ready=%b, required 100 and 01", to, a, rdy);
        end
        tick();
        set_req(0, 1'b1, 12'h104, '0, '0);
        serve(2, DW'($urandom), a, wd, ws, rdy, rdat, early, to);
        tests++;
        if (to || a !== 12'h104 || rdy !== 2'b01) begin
            fails++;
            $display("FAIL burst_second: to=%0b addr=%h m_ready=%b, required 104 and 01", to, a, rdy);
        end
        tick();
        set_req(0, 1'b0, '0, '0, '0);
        serve(2, DW'($urandom), a, wd, ws, rdy, rdat, early, to);
        tests++;
        if (to || a !== 12'h3C8 || rdy !== 2'b10) begin
            fails++;
            $display("FAIL burst_release: to=%0b addr=%h m_ready=%b, required 3c8 and 10", to, a, rdy);
        end
        do_reset();
        set_req(0, 1'b1, 12'h100, '0, '0);
        set_req(1, 1'b1, 12'h2A0, DW'($urandom), '0);
        serve(1, DW'($urandom), a, wd, ws, rdy, rdat, early, to);
        tick();
        set_req(0, 1'b0, '0, '0, '0);
        bad = 1'b0;
        #1;
        if (mem_if.valid !== 1'b0) bad = 1'b1;
        repeat (LOCK_TIMEOUT) begin
            tick();
            #1;
            if (mem_if.valid !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (to || bad) begin
            fails++;
            $display("FAIL lock_hold: to=%0b early_grant=%0b, required memory idle for %0d cycles", to, bad, LOCK_TIMEOUT + 1);
        end
        tick();
        #1;
        tests++;
        if (mem_if.valid !== 1'b1 || mem_if.addr !== 12'h2A0) begin
            fails++;
            $display("FAIL lock_timeout: mem_valid=%b addr=%h, required 1 and 2a0", mem_if.valid, mem_if.addr);
        end
    endtask
`endif

    task automatic test_reset_mid_busy();
        logic [AW-1:0] a, a0; logic [DW-1:0] wd, rdat; logic [NB-1:0] ws; logic [N-1:0] rdy; bit early, to;
        do_reset();
        a0 = AW'($urandom);
        set_req(0, 1'b1, a0, DW'($urandom), 4'hF);
        set_req(1, 1'b1, a0 ^ 12'hFFF, DW'($urandom), 4'hF);
        serve(1, DW'($urandom), a, wd, ws, rdy, rdat, early, to);
        exp_rr = 1;
        tick();
        tick();
        #1;
        tests++;
        if (to || rdy !== 2'b01 || mem_if.valid !== 1'b1 || mem_if.addr !== addr_m[pick(valid_m)]) begin
            fails++;
            $display("FAIL midbusy_setup: to=%0b m_ready=%b mem_valid=%b addr=%h, required 01 1 %h",
                     to, rdy, mem_if.valid, mem_if.addr, addr_m[pick(valid_m)]);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_rr = 0;
        mem_if.ready = 1'b1;
        #1;
        tests++;
        if (mem_if.valid !== 1'b0 || m_if.ready !== '0) begin
            fails++;
            $display("FAIL midbusy_reset: mem_valid=%b m_ready=%b, required 0 and 00", mem_if.valid, m_if.ready);
        end
        tick();
        #1;
        tests++;
        if (mem_if.valid !== 1'b1 || mem_if.addr !== addr_m[pick(valid_m)]) begin
            fails++;
            $display("FAIL midbusy_rr_cleared: mem_valid=%b addr=%h, required 1 and %h", mem_if.valid, mem_if.addr, addr_m[pick(valid_m)]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_if.ready = 1'b0;
        mem_if.rdata = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0, '0);
        test_reset();
        test_contention();
        test_write();
        test_read_data();
        test_random();
`ifdef ARB_BURST_LOCK_EN
        test_burst_lock();
`endif
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
